// File: rtl/bus_sequencer.sv
// bus_sequencer: drive/commit/turnaround sequencer for the shared register bus.
// Exactly one source drives cpu_bus per transfer; index ACC_IDX is never a bus destination.
module bus_sequencer #(
  parameter int DATA_W  = 8,
  parameter int ACC_IDX = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [2:0]        cmd_src,
  input  logic [2:0]        cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  inout  wire  [DATA_W-1:0] cpu_bus,
  output logic [7:0]        read_en,
  output logic [7:0]        write_en,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);
  typedef enum logic [1:0] {IDLE, DRIVE, COMMIT, TURN} state_t;
  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;
  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [2:0]        src_q, src_d;
  logic [2:0]        dst_q, dst_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              reject;
  logic              active;
  logic              drive_bus;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= OP_MOV;
      src_q      <= '0;
      dst_q      <= '0;
      imm_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      imm_q      <= imm_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  // The accumulator only loads from its ALU port, so writing it over the bus is refused.
  assign reject = (cmd_op == OP_RSV) || (cmd_op != OP_PEEK && cmd_dst == 3'(ACC_IDX));
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    dst_d      = dst_q;
    imm_d      = imm_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        src_d   = cmd_src;
        dst_d   = cmd_dst;
        imm_d   = cmd_imm;
        err_d   = reject;
        state_d = reject ? TURN : DRIVE;
      end
      DRIVE:  state_d = COMMIT;
      COMMIT: begin
        state_d    = TURN;
        rsp_data_d = (op_q == OP_PEEK) ? cpu_bus : rsp_data_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs decode straight from the state register so an async reset drops them at once.
  assign active    = (state_q == DRIVE) || (state_q == COMMIT);
  assign drive_bus = active && (op_q == OP_LDI);
  assign cpu_bus   = drive_bus ? imm_q : 'z;
  assign read_en   = (active && op_q != OP_LDI) ? (8'd1 << src_q) : 8'd0;
  assign write_en  = (state_q == COMMIT && op_q != OP_PEEK) ? (8'd1 << dst_q) : 8'd0;
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == TURN);
  assign rsp_err   = (state_q == TURN) && err_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed checks of bus_sequencer against a small register-file model.
// A bench probe weakly "owns" the bus at chosen moments; reading its pattern back proves release.
module tb_bus_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_src = 3'd0;
  logic [2:0] cmd_dst = 3'd0;
  logic [7:0] cmd_imm = 8'h00;
  wire  [7:0] cpu_bus;
  logic [7:0] read_en;
  logic [7:0] write_en;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       probe = 1'b0;
  logic       alu_load = 1'b0;
  logic [7:0] alu_val = 8'h00;
  logic [7:0] regs [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h00};
  logic [7:0] rd_val;
  int total = 0;
  int bad = 0;
  int accepts = 0;
  bus_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .cpu_bus(cpu_bus), .read_en(read_en), .write_en(write_en),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < 8; i++) if (read_en[i]) rd_val = regs[i];
  end
  assign cpu_bus = (read_en != 8'd0) ? rd_val : 'z;
  assign cpu_bus = probe ? 8'h5A : 'z;
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (write_en[i]) regs[i] <= cpu_bus;
    if (alu_load) regs[7] <= alu_val;
    if (rst && cmd_valid && cmd_ready) accepts <= accepts + 1;
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_released(input string tag);
    probe = 1'b1;
    #1;
    chk(tag, cpu_bus, 8'h5A);
    probe = 1'b0;
  endtask
  task automatic issue(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst, input logic [7:0] imm);
    cmd_op = op;
    cmd_src = src;
    cmd_dst = dst;
    cmd_imm = imm;
    cmd_valid = 1'b1;
  endtask
  always @(negedge clk) if (rst) begin
    chk("onehot_read", 8'($countones(read_en) <= 1), 8'd1);
    chk("onehot_write", 8'($countones(write_en) <= 1), 8'd1);
    chk("acc_never_written", {7'd0, write_en[7]}, 8'd0);
    chk("err_needs_valid", {7'd0, rsp_err & ~rsp_valid}, 8'd0);
  end
  initial begin
    #2 rst = 1'b0;
    #4;
    chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_read_en", read_en, 8'h00);
    chk("rst_write_en", write_en, 8'h00);
    chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst_rsp_err", {7'd0, rsp_err}, 8'd0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk_released("rst_bus_released");
    #4 rst = 1'b1;
    tick();
    issue(2'b01, 3'd0, 3'd2, 8'hA5);
    tick();
    cmd_valid = 1'b0;
    cmd_imm = 8'h11;
    chk("ldi_drive_bus", cpu_bus, 8'hA5);
    chk("ldi_drive_we", write_en, 8'h00);
    chk("ldi_drive_re", read_en, 8'h00);
    chk("ldi_drive_ready", {7'd0, cmd_ready}, 8'd0);
    tick();
    chk("ldi_commit_bus", cpu_bus, 8'hA5);
    chk("ldi_commit_we", write_en, 8'h04);
    chk("ldi_commit_rv", {7'd0, rsp_valid}, 8'd0);
    tick();
    chk("ldi_turn_rv", {7'd0, rsp_valid}, 8'd1);
    chk("ldi_turn_err", {7'd0, rsp_err}, 8'd0);
    chk("ldi_turn_we", write_en, 8'h00);
    chk_released("ldi_turn_bus_released");
    tick();
    chk("ldi_idle_ready", {7'd0, cmd_ready}, 8'd1);
    chk("ldi_idle_rv", {7'd0, rsp_valid}, 8'd0);
    chk("ldi_r2", regs[2], 8'hA5);
    chk_released("ldi_idle_bus_released");
    issue(2'b00, 3'd2, 3'd5, 8'h00);
    tick();
    cmd_valid = 1'b0;
    chk("mov_drive_re", read_en, 8'h04);
    chk("mov_drive_we", write_en, 8'h00);
    chk("mov_drive_bus", cpu_bus, 8'hA5);
    tick();
    chk("mov_commit_re", read_en, 8'h04);
    chk("mov_commit_we", write_en, 8'h20);
    tick();
    chk("mov_turn_rv", {7'd0, rsp_valid}, 8'd1);
    chk("mov_turn_re", read_en, 8'h00);
    chk("mov_turn_we", write_en, 8'h00);
    tick();
    chk("mov_r5", regs[5], 8'hA5);
    issue(2'b10, 3'd5, 3'd0, 8'h00);
    tick();
    cmd_valid = 1'b0;
    chk("peek5_drive_re", read_en, 8'h20);
    chk("peek5_drive_we", write_en, 8'h00);
    tick();
    chk("peek5_commit_re", read_en, 8'h20);
    chk("peek5_commit_we", write_en, 8'h00);
    tick();
    chk("peek5_turn_rv", {7'd0, rsp_valid}, 8'd1);
    chk("peek5_data", rsp_data, 8'hA5);
    tick();
    chk("peek5_data_held", rsp_data, 8'hA5);
    alu_load = 1'b1;
    alu_val = 8'h3C;
    tick();
    alu_load = 1'b0;
    issue(2'b10, 3'd7, 3'd0, 8'h00);
    tick();
    cmd_valid = 1'b0;
    chk("peek7_drive_re", read_en, 8'h80);
    tick();
    chk("peek7_commit_re", read_en, 8'h80);
    tick();
    chk("peek7_turn_err", {7'd0, rsp_err}, 8'd0);
    chk("peek7_data", rsp_data, 8'h3C);
    tick();
    for (int k = 0; k < 3; k++) begin
      issue(k == 2 ? 2'b11 : 2'(k), 3'd1, 3'd7, 8'hC3);
      tick();
      cmd_valid = 1'b0;
      chk("rej_rv", {7'd0, rsp_valid}, 8'd1);
      chk("rej_err", {7'd0, rsp_err}, 8'd1);
      chk("rej_re", read_en, 8'h00);
      chk("rej_we", write_en, 8'h00);
      chk("rej_ready", {7'd0, cmd_ready}, 8'd0);
      chk_released("rej_bus_released");
      tick();
      chk("rej_idle_rv", {7'd0, rsp_valid}, 8'd0);
      chk("rej_idle_err", {7'd0, rsp_err}, 8'd0);
      chk("rej_idle_ready", {7'd0, cmd_ready}, 8'd1);
    end
    chk("rej_acc_kept", regs[7], 8'h3C);
    chk("rej_data_kept", rsp_data, 8'h3C);
    accepts = 0;
    issue(2'b01, 3'd0, 3'd3, 8'h77);
    tick();
    issue(2'b00, 3'd1, 3'd6, 8'h00);
    chk("b2b_a_drive_bus", cpu_bus, 8'h77);
    tick();
    chk("b2b_a_commit_bus", cpu_bus, 8'h77);
    chk("b2b_a_commit_we", write_en, 8'h08);
    chk("b2b_a_commit_re", read_en, 8'h00);
    issue(2'b01, 3'd0, 3'd4, 8'h99);
    tick();
    chk("b2b_a_turn_rv", {7'd0, rsp_valid}, 8'd1);
    chk("b2b_a_turn_ready", {7'd0, cmd_ready}, 8'd0);
    tick();
    chk("b2b_idle_ready", {7'd0, cmd_ready}, 8'd1);
    chk("b2b_r3", regs[3], 8'h77);
    chk("b2b_r6_untouched", regs[6], 8'h16);
    tick();
    chk("b2b_b_drive_bus", cpu_bus, 8'h99);
    chk("b2b_b_ready", {7'd0, cmd_ready}, 8'd0);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_b_commit_we", write_en, 8'h10);
    tick();
    chk("b2b_b_turn_rv", {7'd0, rsp_valid}, 8'd1);
    tick();
    chk("b2b_r4", regs[4], 8'h99);
    chk("b2b_accepts", 8'(accepts), 8'd2);
    issue(2'b00, 3'd1, 3'd0, 8'h00);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rstmid_commit_we", write_en, 8'h01);
    chk("rstmid_commit_re", read_en, 8'h02);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_we_drop", write_en, 8'h00);
    chk("rstmid_re_drop", read_en, 8'h00);
    chk("rstmid_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rstmid_rv", {7'd0, rsp_valid}, 8'd0);
    chk_released("rstmid_bus_released");
    tick();
    chk("rstmid_no_rv", {7'd0, rsp_valid}, 8'd0);
    chk("rstmid_data_cleared", rsp_data, 8'h00);
    #3 rst = 1'b1;
    tick();
    chk("rstmid_after_rv", {7'd0, rsp_valid}, 8'd0);
    chk("rstmid_after_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rstmid_after_re", read_en, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
